sig_interp_seq: RTL and testbench

- Sequencer for the sigmoid piecewise-linear interpolator in the output_sig_nn activation path.
- Accepts one signed fixed-point x per valid/ready handshake and splits it into a segment index and a fraction.
- Fetches the two bracketing sample points from a shared single-port, 1-cycle-latency LUT ROM, drives the interpolator's base/next_data/remaining inputs, and registers the result for a valid/ready output.

---
 rtl/sig_interp_seq.sv | 130 +++++++++++++
 tb/tb_sig_interp_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sig_interp_seq.sv
// Sequencer for the sigmoid PWL interpolator: splits x into segment/fraction, fetches bracketing LUT points, registers result.
// Optional segment cache (reuse last base/next on same segment) enabled by SIG_INTERP_SEQ_SEGCACHE_EN.
module sig_interp_seq #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int ADDR_W = DATA_W - FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] interp_base,
  output logic [DATA_W-1:0] interp_next,
  output logic [DATA_W-1:0] interp_remaining,
  input  logic [DATA_W-1:0] interp_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y
);

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_CAP, S_CALC, S_OUT} state_t;

  localparam logic [ADDR_W-1:0] IDX_TOP = '1;
`ifdef SIG_INTERP_SEQ_SEGCACHE_EN
  localparam logic CACHE_EN = 1'b1;
`else
  localparam logic CACHE_EN = 1'b0;
`endif

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [FRAC_W-1:0]   frac_q;
  logic [DATA_W-1:0]   base_q;
  logic [DATA_W-1:0]   next_q;
  logic [DATA_W-1:0]   out_y_q;
  logic                out_vld_q;
  logic                rom_en_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                seg_vld_q;
  logic [ADDR_W-1:0]   in_idx;
  logic                cache_hit;

  // Offset-binary segment number: flipping the sign bit makes x=0 land mid-table.
  assign in_idx    = {~in_x[DATA_W-1], in_x[DATA_W-2:FRAC_W]};
  // idx_q still holds the previous segment while idle, so it doubles as the cache tag.
  assign cache_hit = seg_vld_q && (in_idx == idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      frac_q     <= '0;
      base_q     <= '0;
      next_q     <= '0;
      out_y_q    <= '0;
      out_vld_q  <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      seg_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            idx_q  <= in_idx;
            frac_q <= in_x[FRAC_W-1:0];
            if (cache_hit) begin
              state_q <= S_CALC;
            end else begin
              rom_en_q   <= 1'b1;
              rom_addr_q <= in_idx;
              state_q    <= S_RD0;
            end
          end
        end
        S_RD0: begin
          // Top segment has no upper neighbour; skip the second read.
          if (idx_q != IDX_TOP) begin
            rom_en_q   <= 1'b1;
            rom_addr_q <= idx_q + 1'b1;
          end else begin
            rom_en_q <= 1'b0;
          end
          state_q <= S_RD1;
        end
        S_RD1: begin
          rom_en_q <= 1'b0;
          base_q   <= rom_data;
          if (idx_q != IDX_TOP) begin
            state_q <= S_CAP;
          end else begin
            next_q    <= rom_data;
            seg_vld_q <= CACHE_EN;
            state_q   <= S_CALC;
          end
        end
        S_CAP: begin
          next_q    <= rom_data;
          seg_vld_q <= CACHE_EN;
          state_q   <= S_CALC;
        end
        S_CALC: begin
          out_y_q   <= interp_result;
          out_vld_q <= 1'b1;
          state_q   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign rom_en           = rom_en_q;
  assign rom_addr         = rom_addr_q;
  assign interp_base      = base_q;
  assign interp_next      = next_q;
  assign interp_remaining = {{(DATA_W-FRAC_W){1'b0}}, frac_q};
  assign out_valid        = out_vld_q;
  assign out_y            = out_y_q;

endmodule

// File: tb/tb_sig_interp_seq.sv
// Directed bench for sig_interp_seq with a 1-cycle LUT ROM (table[k]=16k-128) and a behavioural interpolator.
module tb_sig_interp_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = 8'h00;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] interp_base, interp_next, interp_remaining, interp_result;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_y;

  int n_tests = 0;
  int n_fail  = 0;
  int ib, inx, ir;

  always #5 clk = ~clk;

  sig_interp_seq #(.DATA_W(8), .FRAC_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .interp_base(interp_base), .interp_next(interp_next),
    .interp_remaining(interp_remaining), .interp_result(interp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  function automatic logic [7:0] rom_tbl(input logic [3:0] k);
    logic [7:0] v;
    v = {k, 4'b0000} - 8'd128;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= rom_tbl(rom_addr);
  end

  always_comb begin
    ib  = int'($signed(interp_base));
    inx = int'($signed(interp_next));
    ir  = int'(interp_remaining);
    interp_result = 8'(ib + (((inx - ib) * ir) >>> 4));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic [7:0] x, input int exp_lat,
                         input int exp_reads, input logic [3:0] exp_a0, input logic [3:0] exp_a1,
                         input logic [7:0] exp_y, input int stall);
    int cyc, reads;
    logic [3:0] a0, a1;
    logic busy_rdy, held_bad;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_x      = x;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0; reads = 0; a0 = '0; a1 = '0; busy_rdy = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rom_en) begin
        if (reads == 0) a0 = rom_addr;
        if (reads == 1) a1 = rom_addr;
        reads++;
      end
      if (in_ready) busy_rdy = 1'b1;
    end
    chk({tag, ".lat"},   32'(cyc),      32'(exp_lat));
    chk({tag, ".reads"}, 32'(reads),    32'(exp_reads));
    chk({tag, ".addr0"}, 32'(a0),       32'(exp_a0));
    chk({tag, ".addr1"}, 32'(a1),       32'(exp_a1));
    chk({tag, ".y"},     32'(out_y),    32'(exp_y));
    chk({tag, ".busy"},  32'(busy_rdy), 32'd0);
    held_bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (out_y !== exp_y || !out_valid || in_ready || rom_en) held_bad = 1'b1;
    end
    if (stall > 0) begin
      chk({tag, ".hold"}, 32'(held_bad), 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, ".drain"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    logic stray;
    #12;
    chk("rst.in_ready",  32'(in_ready),    32'd1);
    chk("rst.out_valid", 32'(out_valid),   32'd0);
    chk("rst.rom_en",    32'(rom_en),      32'd0);
    chk("rst.rom_addr",  32'(rom_addr),    32'd0);
    chk("rst.out_y",     32'(out_y),       32'd0);
    chk("rst.base",      32'(interp_base), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("centre", 8'h00, 5, 2, 4'd8,  4'd9,  8'h00, 0);
    run_txn("mid",    8'h18, 5, 2, 4'd9,  4'd10, 8'h18, 0);
    run_txn("top",    8'h7F, 4, 1, 4'd15, 4'd0,  8'h70, 0);
    run_txn("bottom", 8'h80, 5, 2, 4'd0,  4'd1,  8'h80, 0);
    run_txn("negh",   8'hF8, 5, 2, 4'd7,  4'd8,  8'hF8, 0);
    run_txn("bp",     8'h00, 5, 2, 4'd8,  4'd9,  8'h00, 5);

    // Abort a fetch with reset asserted during RD1.
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 8'h18;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.state", 32'({in_ready, out_valid, rom_en, rom_addr, out_y}),
        32'({1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || rom_en) stray = 1'b1;
    end
    chk("arst.quiet", 32'(stray), 32'd0);

    run_txn("post", 8'h18, 5, 2, 4'd9, 4'd10, 8'h18, 0);
`ifdef SIG_INTERP_SEQ_SEGCACHE_EN
    run_txn("cache", 8'h1C, 2, 0, 4'd0, 4'd0, 8'h1C, 0);
`else
    run_txn("cache", 8'h1C, 5, 2, 4'd9, 4'd10, 8'h1C, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end
endmodule
